// File: rtl/spi_target_regbank.sv
// rtl/spi_target_regbank.sv - SPI mode-0 target with a 16 x 8-bit register bank shared with a Wishbone slave
//
// Ports:
//   wb_clk_i, wb_rst_i        system clock, asynchronous active-high reset
//   wbs_*                     Wishbone slave: regs at index 0..15, STATUS at index 16
//   spi_sclk_i/csb_i/mosi_i   asynchronous SPI inputs from the external controller
//   spi_miso_o, spi_miso_oeb  MISO data and active-low pad output enable
//   irq_o                     level interrupt, WR_FLAG & IRQ_EN, registered
module spi_target_regbank #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_RESET   = 8'h00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        spi_sclk_i,
    input  logic        spi_csb_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oeb,
    output logic        irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, mosi_sync_q;
    logic sclk_prev_q, csb_prev_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  rx_q, tx_q;
    logic [3:0]  addr_q;
    logic        is_write_q;
    logic        miso_q;
    logic [7:0]  regs_q [16];
    logic        wr_flag_q, irq_en_q, irq_q;
    logic        ack_q;
    logic [31:0] dat_q;

    logic sclk_s, csb_s, mosi_s;
    logic sclk_rise, sclk_fall, csb_fall, csb_rise;
    logic [7:0] rx_next;
    logic shift_en, cmd_done, byte_done, spi_commit, tx_shift_en, oeb;

    logic        wb_req, wb_reg_we, status_we;
    logic [4:0]  wb_idx;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign csb_s   = csb_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csb_fall  = csb_prev_q & ~csb_s;
    assign csb_rise  = ~csb_prev_q & csb_s;
    assign rx_next   = {rx_q[6:0], mosi_s};

    // FSM: state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state; csb rising aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (csb_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (csb_fall) state_d = ST_CMD;
                ST_CMD:  if (cmd_done) state_d = ST_DATA;
                ST_DATA: state_d = ST_DATA;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs and datapath strobes; SCLK edges only count while csb is low
    always_comb begin
        shift_en    = 1'b0;
        cmd_done    = 1'b0;
        byte_done   = 1'b0;
        spi_commit  = 1'b0;
        tx_shift_en = 1'b0;
        oeb         = 1'b1;
        if (state_q != ST_IDLE) begin
            oeb      = 1'b0;
            shift_en = sclk_rise & ~csb_s & ~csb_rise;
        end
        if (state_q == ST_CMD) begin
            cmd_done = shift_en & (bit_cnt_q == 3'd7);
        end
        if (state_q == ST_DATA) begin
            byte_done   = shift_en & (bit_cnt_q == 3'd7);
            spi_commit  = byte_done & is_write_q;
            tx_shift_en = sclk_fall & ~csb_s & ~csb_rise & ~is_write_q;
        end
    end

    // Synchronizers, edge history and SPI shift datapath
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 4'd0;
            is_write_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            csb_prev_q  <= csb_s;
            if (csb_fall || csb_rise) begin
                bit_cnt_q <= 3'd0;
                rx_q      <= 8'h00;
                miso_q    <= 1'b0;
            end else if (shift_en) begin
                rx_q      <= rx_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (cmd_done) begin
                    is_write_q <= rx_next[7];
                    addr_q     <= rx_next[3:0];
                    if (!rx_next[7]) tx_q <= regs_q[rx_next[3:0]];
                end else if (byte_done) begin
                    addr_q <= addr_q + 4'd1;
                    if (!is_write_q) tx_q <= regs_q[addr_q + 4'd1];
                end
            end else if (tx_shift_en) begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
            end
        end
    end

    assign wb_req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wb_idx    = wbs_adr_i[6:2];
    assign wb_reg_we = wb_req & wbs_we_i & wbs_sel_i[0] & ~wb_idx[4];
    assign status_we = wb_req & wbs_we_i & (wb_idx == 5'd16);

    // Register bank; the SPI commit is assigned last so it wins a same-cycle collision
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= REG_RESET;
        end else begin
            if (wb_reg_we)  regs_q[wb_idx[3:0]] <= wbs_dat_i[7:0];
            if (spi_commit) regs_q[addr_q]      <= rx_next;
        end
    end

    // STATUS; a set from SPI overrides a simultaneous write-1-to-clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_flag_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (status_we && wbs_dat_i[0]) wr_flag_q <= 1'b0;
            if (spi_commit)                wr_flag_q <= 1'b1;
            if (status_we)                 irq_en_q  <= wbs_dat_i[8];
            irq_q <= wr_flag_q & irq_en_q;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (!wb_idx[4])
            rd_data = {24'h0, regs_q[wb_idx[3:0]]};
        else if (wb_idx == 5'd16)
            rd_data = {23'h0, irq_en_q, 6'h0, ~csb_s, wr_flag_q};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= wb_req;
            dat_q <= wb_req ? rd_data : 32'h0;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign spi_miso_o   = miso_q;
    assign spi_miso_oeb = oeb;
    assign irq_o        = irq_q;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[31:7], wbs_adr_i[1:0], wbs_dat_i[31:9]};

endmodule

// File: tb/tb_spi_target_regbank.sv
// tb/tb_spi_target_regbank.sv - directed self-checking bench for spi_target_regbank
module tb_spi_target_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        sclk, csb, mosi;
    logic        miso, miso_oeb;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd;
    logic [7:0]  rxb;
    logic        rbit;
    logic [7:0]  pat;

    spi_target_regbank #(.SYNC_STAGES(2), .REG_RESET(8'h00)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (dat_i),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .spi_sclk_i   (sclk),
        .spi_csb_i    (csb),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .spi_miso_oeb (miso_oeb),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] idx, input logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'h1;
        adr = {25'h0, idx, 2'b00}; dat_i = d;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] idx, output logic [31:0] d);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'h1;
        adr = {25'h0, idx, 2'b00};
        @(negedge clk);
        check("wb_ack", {31'h0, ack}, 32'h1);
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
    endtask

    // One mode-0 bit: MOSI set, controller samples MISO just before SCLK rises
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #40;
        r = miso;
        sclk = 1'b1;
        #40;
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic frame_start;
        @(negedge clk);
        csb = 1'b0;
        #80;
    endtask

    task automatic frame_end;
        #40;
        csb = 1'b1;
        #80;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'h0; adr = 32'h0; sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oeb", {31'h0, miso_oeb}, 32'h1);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wb_read(5'd16, rd); check("rst_status", rd, 32'h0);
        wb_read(5'd5, rd);  check("rst_reg5", rd, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // SPI write burst starting at index 3
        frame_start;
        spi_byte(8'h83, rxb);
        spi_byte(8'hA5, rxb);
        spi_byte(8'h5A, rxb);
        frame_end;
        wb_read(5'd3, rd);  check("wr_reg3", rd, 32'h0000_00A5);
        wb_read(5'd4, rd);  check("wr_reg4", rd, 32'h0000_005A);
        wb_read(5'd16, rd); check("wr_status", rd, 32'h0000_0001);
        wb_write(5'd16, 32'h0000_0100);
        repeat (2) @(negedge clk);
        check("irq_set", {31'h0, irq}, 32'h1);
        wb_write(5'd16, 32'h0000_0101);
        repeat (2) @(negedge clk);
        check("irq_clr", {31'h0, irq}, 32'h0);
        wb_read(5'd16, rd); check("status_irqen", rd, 32'h0000_0100);

        // SPI read burst across the 15 -> 0 wrap
        wb_write(5'd15, 32'h11);
        wb_write(5'd0, 32'h22);
        frame_start;
        check("rd_oeb_low", {31'h0, miso_oeb}, 32'h0);
        wb_read(5'd16, rd); check("status_busy", rd, 32'h0000_0102);
        spi_byte(8'h0F, rxb);
        spi_byte(8'h00, rxb); check("rd_byte15", {24'h0, rxb}, 32'h11);
        spi_byte(8'h00, rxb); check("rd_byte0", {24'h0, rxb}, 32'h22);
        frame_end;
        check("rd_oeb_high", {31'h0, miso_oeb}, 32'h1);
        wb_read(5'd16, rd); check("rd_status", rd, 32'h0000_0100);

        // Aborted partial byte, then a full frame
        wb_write(5'd2, 32'h5C);
        frame_start;
        spi_byte(8'h82, rxb);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, rbit);
        frame_end;
        wb_read(5'd2, rd);  check("part_reg2", rd, 32'h5C);
        wb_read(5'd16, rd); check("part_status", rd, 32'h0000_0100);
        check("part_idle_oeb", {31'h0, miso_oeb}, 32'h1);
        frame_start;
        spi_byte(8'h82, rxb);
        spi_byte(8'h77, rxb);
        frame_end;
        wb_read(5'd2, rd);  check("full_reg2", rd, 32'h77);
        wb_write(5'd16, 32'h0000_0001);
        wb_read(5'd16, rd); check("w1c_status", rd, 32'h0);

        // Same-cycle SPI commit and Wishbone write to index 7
        pat = 8'h33;
        frame_start;
        spi_byte(8'h87, rxb);
        for (int i = 7; i >= 1; i--) spi_bit(pat[i], rbit);
        mosi = pat[0];
        #40;
        sclk = 1'b1;
        // rise reaches the commit on the third posedge after it
        #20;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'h1;
        adr = {25'h0, 5'd7, 2'b00}; dat_i = 32'hCC;
        #10;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        #10;
        sclk = 1'b0;
        frame_end;
        wb_read(5'd7, rd);  check("collide_reg7", rd, 32'h33);
        wb_read(5'd16, rd); check("collide_status", rd, 32'h1);

        // Reset in the middle of a read burst
        wb_write(5'd1, 32'h9E);
        frame_start;
        spi_byte(8'h01, rxb);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, rbit);
        #40;
        check("mid_miso", {31'h0, miso}, 32'h1);
        check("mid_oeb", {31'h0, miso_oeb}, 32'h0);
        rst = 1'b1;
        #2;
        check("rstmid_oeb", {31'h0, miso_oeb}, 32'h1);
        check("rstmid_miso", {31'h0, miso}, 32'h0);
        csb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #80;
        wb_read(5'd16, rd); check("post_status", rd, 32'h0);
        frame_start;
        spi_byte(8'h01, rxb);
        spi_byte(8'h00, rxb); check("post_read1", {24'h0, rxb}, 32'h00);
        frame_end;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_target_regbank.md
Name: spi_target_regbank

Overview:
- SPI mode-0 target (responder): the far end of the SPI0/SPI1 controller links in the peripheral macro.
- An external SPI controller reads and writes a 16 x 8-bit register bank through it.
- Firmware sees the same bank through a Wishbone slave port, plus one status/control register.
- Used for SPI loopback bring-up on spare user I/O, and as a host-mailbox block.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input synchronizer (legal values 2..3).
- REG_RESET, 8'h00, reset value of every register-bank entry.

Ports:
- wb_clk_i  in  1  system clock; all logic runs in this domain.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; only bit 0 is used.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; bits [6:2] are the register index.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- spi_sclk_i  in  1  SPI clock from the external controller; asynchronous.
- spi_csb_i  in  1  chip select, active-low; asynchronous.
- spi_mosi_i  in  1  controller-to-target data.
- spi_miso_o  out  1  target-to-controller data.
- spi_miso_oeb  out  1  pad output-enable for MISO, active-low.
- irq_o  out  1  interrupt, level.

Behaviour:
- Reset values:
  - All outputs 0, except spi_miso_oeb = 1.
  - regs[0..15] = REG_RESET; STATUS = 0; FSM in IDLE.
- Input synchronization and timing:
  - sclk, csb and mosi each pass through a SYNC_STAGES synchronizer; csb synchronizer flops reset to 1.
  - SCLK edges are detected from the synchronized sclk (previous vs current sample).
  - SCLK frequency must be at most wb_clk_i / 8.
- SPI framing:
  - Mode 0, MSB first.
  - MOSI is sampled at the detected SCLK rise; MISO is updated at the detected SCLK fall.
- FSM transitions:
  - IDLE -> CMD on synchronized csb falling. Bit counter cleared, shifter cleared, spi_miso_oeb = 0, spi_miso_o = 0.
  - CMD: after 8 rises, capture the command byte, then go to DATA.
    - Command bit 7 is W (1 = write, 0 = read); bits 6:4 ignored; bits 3:0 give the start address A.
    - If read, load the TX shifter with regs[A] in the same cycle.
  - DATA, write: each completed byte commits regs[A] <= byte, sets STATUS.WR_FLAG, then A <= A + 1 mod 16 (15 wraps to 0).
  - DATA, read: the MISO bit 7 of regs[A] appears at the first fall after the command byte.
    - After each 8th rise: A <= A + 1 mod 16 and the shifter reloads with regs[A + 1].
    - Read data is snapshotted at load time.
    - During reads, MOSI bits are ignored.
  - Any state -> IDLE on synchronized csb rising. A partial byte is discarded (no commit); spi_miso_oeb = 1, spi_miso_o = 0.
  - SCLK edges while csb is high are ignored.
- Wishbone slave:
  - A request is stb & cyc & !ack. wbs_ack_o is a one-cycle pulse in the next cycle, so at most one ack every 2 cycles.
  - Index 0..15: write regs[idx] <= wbs_dat_i[7:0] when sel[0]; read returns {24'h0, regs[idx]}.
  - Index 16 STATUS:
    - bit 0 WR_FLAG: write 1 to clear.
    - bit 1 BUSY: read-only, 1 while synchronized csb is low.
    - bit 8 IRQ_EN: read/write.
    - Other bits read 0.
  - Index 17..31: writes ignored, read 0.
  - wbs_dat_o is registered with the ack and is 0 when no ack.
- Collisions:
  - SPI commit and Wishbone write to the same register in the same cycle: the SPI value wins.
  - WR_FLAG set and a W1C clear in the same cycle: the flag stays set.
- irq_o = STATUS.WR_FLAG & STATUS.IRQ_EN, registered with 1-cycle latency.
- Reset asserted mid-transaction: immediate return to the reset state; after release the block waits for the next csb falling edge.

Test Plan:
- Reset, then WB read of index 16 -> 0x00000000; spi_miso_oeb = 1; WB read of index 5 -> 0x00000000.
- SPI csb low; send 0x83, 0xA5, 0x5A; csb high -> WB reads index 3 = 0xA5, index 4 = 0x5A; STATUS = 0x1. With IRQ_EN set, irq_o = 1; writing 0x101 to STATUS clears irq_o and keeps IRQ_EN.
- WB writes 0x11 to index 15 and 0x22 to index 0; SPI sends 0x0F then 16 dummy bits -> MISO returns 0x11, 0x22 (wrap); spi_miso_oeb = 0 only while csb is low; WR_FLAG stays 0.
- SPI 0x82 plus 4 data bits, then csb rises -> index 2 unchanged, WR_FLAG = 0, FSM back in IDLE; the next full 0x82, 0x77 frame writes 0x77.
- Same-cycle SPI commit to index 7 (0x33) and WB write to index 7 (0xCC) -> index 7 reads 0x33.
- Assert wb_rst_i mid-read burst -> spi_miso_oeb = 1 and MISO = 0 immediately; after release, a new 0x01 read returns REG_RESET.
